// File: rtl/tile_renderer_pkg.sv
// Shared definitions for the tile renderer: field widths, tile codes, grid
// limits, colour palette, FSM state encoding and the plot request payload.
package tile_renderer_pkg;

    localparam int unsigned TX_W  = 4;
    localparam int unsigned TY_W  = 4;
    localparam int unsigned TV_W  = 3;
    localparam int unsigned VX_W  = 8;
    localparam int unsigned VY_W  = 7;
    localparam int unsigned COL_W = 3;

    // Largest legal grid column / row
    localparam int unsigned MAX_X = 11;
    localparam int unsigned MAX_Y = 9;

    // Tile codes
    localparam logic [TV_W-1:0] TILE_FLOOR  = 3'b000;
    localparam logic [TV_W-1:0] TILE_PLAYER = 3'b001;
    localparam logic [TV_W-1:0] TILE_WALL   = 3'b010;
    localparam logic [TV_W-1:0] TILE_BLOCK  = 3'b011;
    localparam logic [TV_W-1:0] TILE_BOMB   = 3'b100;

    // Colours {R,G,B}
    localparam logic [COL_W-1:0] COL_BLACK  = 3'b000;
    localparam logic [COL_W-1:0] COL_BLUE   = 3'b001;
    localparam logic [COL_W-1:0] COL_WHITE  = 3'b111;
    localparam logic [COL_W-1:0] COL_YELLOW = 3'b110;
    localparam logic [COL_W-1:0] COL_RED    = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_DRAW = 2'd2
    } state_e;

    typedef struct packed {
        logic [TX_W-1:0] tx;
        logic [TY_W-1:0] ty;
        logic [TV_W-1:0] tv;
    } plot_req_t;

    localparam int unsigned REQ_W = $bits(plot_req_t);

    // Tile code to pixel colour; undefined codes render black
    function automatic logic [COL_W-1:0] palette(input logic [TV_W-1:0] tv);
        logic [COL_W-1:0] c;
        case (tv)
            TILE_FLOOR:  c = COL_BLACK;
            TILE_PLAYER: c = COL_BLUE;
            TILE_WALL:   c = COL_WHITE;
            TILE_BLOCK:  c = COL_YELLOW;
            TILE_BOMB:   c = COL_RED;
            default:     c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tile_renderer_fifo.sv
// Synchronous request FIFO with occupancy count.
//   clk, resetn      : clock, async active-low reset
//   push_i, wdata_i  : enqueue (ignored when full, even if popping same edge)
//   pop_i, rdata_o   : dequeue (ignored when empty); rdata_o is the current head
//   full_o, empty_o  : status
//   count_o          : occupancy 0..DEPTH
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module tile_renderer_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/tile_renderer.sv
// Expands tile plot requests into TILE_SIZE x TILE_SIZE pixel writes, one per
// clock, row-major with x fastest.
//   clk, resetn                 : clock, async active-low reset
//   plot, tile_x/y, tile_val    : request strobe and payload (queued in a FIFO)
//   ready                       : FIFO not full
//   busy                        : FIFO non-empty or renderer not idle
//   overflow                    : sticky, a request arrived while the FIFO was full
//   vga_x, vga_y, colour, writeEn : registered pixel write to the VGA adapter
module tile_renderer
    import tile_renderer_pkg::*;
#(
    parameter int unsigned TILE_SIZE  = 8,
    parameter int unsigned X_OFF      = 32,
    parameter int unsigned Y_OFF      = 20,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              plot,
    input  logic [TX_W-1:0]   tile_x,
    input  logic [TY_W-1:0]   tile_y,
    input  logic [TV_W-1:0]   tile_val,
    output logic              ready,
    output logic              busy,
    output logic              overflow,
    output logic [VX_W-1:0]   vga_x,
    output logic [VY_W-1:0]   vga_y,
    output logic [COL_W-1:0]  colour,
    output logic              writeEn
);

    localparam int unsigned CW    = $clog2(TILE_SIZE);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    plot_req_t         req_in, head;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [CNT_W-1:0]  fifo_count;

    logic [TX_W-1:0]   tx_q, tx_d;
    logic [TY_W-1:0]   ty_q, ty_d;
    logic [TV_W-1:0]   tv_q, tv_d;
    logic [CW-1:0]     px_q, px_d;
    logic [CW-1:0]     py_q, py_d;
    logic [VX_W-1:0]   vga_x_q, vga_x_d;
    logic [VY_W-1:0]   vga_y_q, vga_y_d;
    logic [COL_W-1:0]  colour_q, colour_d;
    logic              we_q, we_d;
    logic              overflow_q, overflow_d;

    // Tile currently being addressed: the FIFO head on the POP cycle, else the latched one
    logic [TX_W-1:0]   sel_tx;
    logic [TY_W-1:0]   sel_ty;
    logic [TV_W-1:0]   sel_tv;

    assign req_in   = '{tx: tile_x, ty: tile_y, tv: tile_val};
    assign fifo_pop = (state_q == ST_POP);

    tile_renderer_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (plot),
        .wdata_i (req_in),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign ready    = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign busy     = !fifo_empty || (state_q != ST_IDLE);
    assign overflow = overflow_q;
    assign vga_x    = vga_x_q;
    assign vga_y    = vga_y_q;
    assign colour   = colour_q;
    assign writeEn  = we_q;

    assign overflow_d = overflow_q || (plot && fifo_full);

    assign sel_tx = (state_q == ST_POP) ? head.tx : tx_q;
    assign sel_ty = (state_q == ST_POP) ? head.ty : ty_q;
    assign sel_tv = (state_q == ST_POP) ? head.tv : tv_q;

    // Next state, counters and the next registered pixel write
    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        tv_d     = tv_q;
        px_d     = px_q;
        py_d     = py_q;
        we_d     = 1'b0;
        vga_x_d  = vga_x_q;
        vga_y_d  = vga_y_q;
        colour_d = colour_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_POP;
            end
            ST_POP: begin
                tx_d = head.tx;
                ty_d = head.ty;
                tv_d = head.tv;
                px_d = '0;
                py_d = '0;
                if ((head.tx > TX_W'(MAX_X)) || (head.ty > TY_W'(MAX_Y))) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAW;
                    we_d    = 1'b1;
                end
            end
            ST_DRAW: begin
                if ((px_q == CW'(TILE_SIZE - 1)) && (py_q == CW'(TILE_SIZE - 1))) begin
                    state_d = ST_IDLE;
                end else begin
                    we_d = 1'b1;
                    px_d = px_q + CW'(1);
                    if (px_q == CW'(TILE_SIZE - 1)) py_d = py_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (we_d) begin
            vga_x_d  = VX_W'(X_OFF) + VX_W'(sel_tx) * VX_W'(TILE_SIZE) + VX_W'(px_d);
            vga_y_d  = VY_W'(Y_OFF) + VY_W'(sel_ty) * VY_W'(TILE_SIZE) + VY_W'(py_d);
            colour_d = palette(sel_tv);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            tx_q       <= '0;
            ty_q       <= '0;
            tv_q       <= '0;
            px_q       <= '0;
            py_q       <= '0;
            vga_x_q    <= '0;
            vga_y_q    <= '0;
            colour_q   <= '0;
            we_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            tv_q       <= tv_d;
            px_q       <= px_d;
            py_q       <= py_d;
            vga_x_q    <= vga_x_d;
            vga_y_q    <= vga_y_d;
            colour_q   <= colour_d;
            we_q       <= we_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
